lm_sm_sequencer: RTL

Sequencer for load-multiple / store-multiple instructions. It walks the 8-bit register-list immediate and emits one register index per step. That index drives the 3-bit select of the 8-way 16-bit register-read mux, so each step picks the register to store or the register slot to load. It also generates the matching sequential memory address and signals completion to the main control FSM.

---
 rtl/lm_sm_sequencer_pkg.sv | 25 ++
 rtl/lm_sm_sequencer_pri_enc.sv | 24 ++
 rtl/lm_sm_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared types and constants for the load/store-multiple sequencer and the
// main control FSM that drives it.
package lm_sm_sequencer_pkg;

    localparam int LM_DATA_W  = 16;
    localparam int LM_REG_CNT = 8;
    localparam int LM_SEL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } lm_state_e;

    // Register-read mux select values for the architectural registers.
    localparam logic [LM_SEL_W-1:0] R0 = 3'd0;
    localparam logic [LM_SEL_W-1:0] R1 = 3'd1;
    localparam logic [LM_SEL_W-1:0] R2 = 3'd2;
    localparam logic [LM_SEL_W-1:0] R3 = 3'd3;
    localparam logic [LM_SEL_W-1:0] R4 = 3'd4;
    localparam logic [LM_SEL_W-1:0] R5 = 3'd5;
    localparam logic [LM_SEL_W-1:0] R6 = 3'd6;
    localparam logic [LM_SEL_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/lm_sm_sequencer_pri_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit of in_vec, plus a flag telling whether any bit is set.
module pri_enc_8_3 #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic [IN_W-1:0]  in_vec,
    output logic [OUT_W-1:0] idx,
    output logic             any_set
);

    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        // Scan from the top down so the lowest set bit wins.
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx     = OUT_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: walks the register-list mask lowest bit first,
// emitting one register select and sequential memory address per transfer.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int DATA_W  = LM_DATA_W,
    parameter int REG_CNT = LM_REG_CNT,
    parameter int SEL_W   = LM_SEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [REG_CNT-1:0] reg_list,
    input  logic [DATA_W-1:0]  base_addr,
    input  logic               advance,
    output logic               busy,
    output logic               valid,
    output logic [SEL_W-1:0]   reg_sel,
    output logic [DATA_W-1:0]  mem_addr,
    output logic               last,
    output logic               done
);

    lm_state_e          state_q, state_d;
    logic [REG_CNT-1:0] mask_q, mask_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic [SEL_W-1:0]   enc_idx;
    logic               enc_any;

    pri_enc_8_3 #(
        .IN_W  (REG_CNT),
        .OUT_W (SEL_W)
    ) u_pri_enc (
        .in_vec  (mask_q),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = reg_list;
                    addr_d  = base_addr;
                    state_d = (reg_list != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (advance && enc_any) begin
                    // m & (m-1) drops exactly the lowest set bit, i.e. the
                    // register currently presented on reg_sel.
                    mask_d = mask_q & (mask_q - REG_CNT'(1));
                    addr_d = addr_q + DATA_W'(1);
                    if (mask_d == '0) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FIN);
        last_d  = valid_d && (mask_d != '0)
                  && ((mask_d & (mask_d - REG_CNT'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Select is forced to zero between transfers; consumers qualify with valid.
    assign reg_sel  = valid_q ? enc_idx : '0;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign last     = last_q;
    assign done     = done_q;

endmodule
